atm_entrada_teclado: RTL and testbench
======================================

// Module: atm_entrada_teclado
// PURPOSE
//  Keypad front-end for the ATM controller. Turns raw keypad events into the
//  controller's digit interface (DIGITO/DIGITO_STB) while in PIN mode.
//  In amount mode it accumulates decimal digits into a binary amount
//  (MONTO/MONTO_STB). Sits directly upstream of the ATM FSM.
// PARAMETERS
//  ANCHO_MONTO   32  width of MONTO and of the internal accumulator
//  MAX_DIGITOS    9  max decimal digits accepted per amount (9 fits 32 bits)
// PORTS
//  CLK               in   1            system clock, rising edge
//  RESET             in   1            asynchronous, active-low reset
//  TECLA_VALIDA      in   1            level: a key is held; one event per rising edge
//  TECLA             in   4            key code: 0-9 digit, A=ENTER, B=CLEAR, C-F unused
//  MODO              in   1            0=PIN entry, 1=amount entry
//  DIGITO            out  4            last PIN digit, valid with DIGITO_STB
//  DIGITO_STB        out  1            1-cycle pulse per PIN digit
//  MONTO             out  ANCHO_MONTO  committed amount, held until next commit
//  MONTO_STB         out  1            1-cycle pulse when MONTO is updated
//  DESBORDE          out  1            sticky: an amount digit was rejected
//  CUENTA_DIGITOS    out  4            digits currently in accumulator
// BEHAVIOUR
//  Reset (RESET=0, async): all outputs 0, accumulator 0, key-edge register 0,
//   state to PIN if MODO=0 else ESPERA.
//  Key event: ev = TECLA_VALIDA & ~tv_q. tv_q is registered each cycle.
//   TECLA is sampled in the ev cycle. A held key produces exactly one event.
//  Outputs are registered. All strobes assert on the cycle after ev
//   (latency 1) and last exactly 1 cycle.
//  States: PIN, ESPERA (amount, count=0), ACUM (amount, count>0), ENTREGA.
//  PIN: digit ev -> DIGITO<=TECLA, DIGITO_STB=1.
//   ENTER, CLEAR and codes C-F are ignored. DIGITO holds its value between strobes.
//  ESPERA: digit ev -> acc<=TECLA, count<=1, go to ACUM.
//   ENTER is ignored (no zero-length amount). CLEAR clears DESBORDE.
//  ACUM, digit ev:
//   - if count==MAX_DIGITOS, or acc*10+d > 2^ANCHO_MONTO-1: digit dropped,
//     DESBORDE<=1, acc and count unchanged.
//   - else acc<=acc*10+d and count++.
//   - acc*10 is computed as (acc<<3)+(acc<<1) in ANCHO_MONTO+4 bits.
//  ACUM, ENTER: MONTO<=acc, go to ENTREGA.
//  ACUM, CLEAR: acc<=0, count<=0, DESBORDE<=0, go to ESPERA.
//  ENTREGA: MONTO_STB=1 for this cycle only. acc, count and DESBORDE are
//   cleared. Next state is ESPERA (MODO=1) or PIN (MODO=0). A key event in
//   this cycle is discarded.
//  Mode change (MODO differs from the registered MODO): the accumulator,
//   count and DESBORDE are cleared the same cycle. State goes to PIN or
//   ESPERA, and a key event in that cycle is discarded. A MONTO_STB already
//   scheduled (ENTREGA) still fires.
//  A new key event while a previous key is still held is impossible by
//   construction (an edge is required).
//  Reset mid-entry aborts with no strobe. MONTO returns to 0.
//  CUENTA_DIGITOS mirrors count. It is 0 in PIN state.
// TESTING
//  T1 MODO=0, keys 1,2,3,4, each held 3 cycles -> four DIGITO_STB pulses,
//     DIGITO=1,2,3,4, one per key.
//  T2 MODO=1, keys 5,0,0,ENTER -> one MONTO_STB, MONTO=500, CUENTA_DIGITOS 0 after.
//  T3 MODO=1, ten 9s then ENTER -> 10th digit dropped, DESBORDE=1,
//     MONTO=999999999.
//  T4 MODO=1, keys 7,CLEAR,ENTER,3,ENTER -> no strobe on first ENTER,
//     single MONTO_STB with MONTO=3.
//  T5 MODO=1, keys 4,2, then MODO->0, then key 9 -> accumulator cleared,
//     no MONTO_STB, DIGITO_STB with DIGITO=9.
//  T6 RESET pulsed low async mid-amount (after keys 8,8) -> all outputs 0
//     immediately. A following ENTER produces no strobe.

Source files
------------

// File: rtl/atm_entrada_teclado.sv
// Keypad front-end for the ATM controller: forwards PIN digits and accumulates
// decimal amount entry into a binary amount with overflow detection.
module atm_entrada_teclado #(
  parameter int unsigned ANCHO_MONTO = 32,
  parameter int unsigned MAX_DIGITOS = 9
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   TECLA_VALIDA,
  input  logic [3:0]             TECLA,
  input  logic                   MODO,
  output logic [3:0]             DIGITO,
  output logic                   DIGITO_STB,
  output logic [ANCHO_MONTO-1:0] MONTO,
  output logic                   MONTO_STB,
  output logic                   DESBORDE,
  output logic [3:0]             CUENTA_DIGITOS
);

  localparam int unsigned AW = ANCHO_MONTO;
  localparam int unsigned PW = ANCHO_MONTO + 4;
  localparam int unsigned CW = 4;
  localparam logic [3:0]    TECLA_ENTER = 4'hA;
  localparam logic [3:0]    TECLA_CLEAR = 4'hB;
  localparam logic [3:0]    TECLA_NUEVE = 4'd9;
  localparam logic [CW-1:0] MAX_CNT     = CW'(MAX_DIGITOS);

  // ST_IDLE acts as PIN when MODO=0 and as ESPERA (empty amount) when MODO=1.
  typedef enum logic [1:0] {ST_IDLE, ST_ACUM, ST_ENTREGA} estado_e;

  estado_e         estado_q, estado_d;
  logic            tv_q, modo_q, primed_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cuenta_q, cuenta_d;
  logic            desborde_q, desborde_d;
  logic [3:0]      digito_q, digito_d;
  logic            digito_stb_q, digito_stb_d;
  logic [AW-1:0]   monto_q, monto_d;
  logic            monto_stb_q, monto_stb_d;

  logic            ev, es_digito, cambio_modo, prod_desborda;
  logic [PW-1:0]   prod;

  // Mode-change detection is held off until MODO has been sampled once after reset.
  always_comb begin
    ev            = TECLA_VALIDA & ~tv_q;
    es_digito     = (TECLA <= TECLA_NUEVE);
    cambio_modo   = primed_q & (MODO != modo_q);
    prod          = (PW'(acc_q) << 3) + (PW'(acc_q) << 1) + PW'(TECLA);
    prod_desborda = |prod[PW-1:AW];
  end

  always_comb begin
    estado_d     = estado_q;
    acc_d        = acc_q;
    cuenta_d     = cuenta_q;
    desborde_d   = desborde_q;
    digito_d     = digito_q;
    digito_stb_d = 1'b0;
    monto_d      = monto_q;
    monto_stb_d  = 1'b0;

    if (cambio_modo) begin
      acc_d      = '0;
      cuenta_d   = '0;
      desborde_d = 1'b0;
      estado_d   = ST_IDLE;
    end else begin
      case (estado_q)
        ST_IDLE: begin
          if (ev) begin
            if (!MODO) begin
              if (es_digito) begin
                digito_d     = TECLA;
                digito_stb_d = 1'b1;
              end
            end else if (es_digito) begin
              acc_d    = AW'(TECLA);
              cuenta_d = CW'(1);
              estado_d = ST_ACUM;
            end else if (TECLA == TECLA_CLEAR) begin
              desborde_d = 1'b0;
            end
          end
        end
        ST_ACUM: begin
          if (ev) begin
            if (es_digito) begin
              if ((cuenta_q == MAX_CNT) || prod_desborda) begin
                desborde_d = 1'b1;
              end else begin
                acc_d    = prod[AW-1:0];
                cuenta_d = cuenta_q + CW'(1);
              end
            end else if (TECLA == TECLA_ENTER) begin
              monto_d     = acc_q;
              monto_stb_d = 1'b1;
              estado_d    = ST_ENTREGA;
            end else if (TECLA == TECLA_CLEAR) begin
              acc_d      = '0;
              cuenta_d   = '0;
              desborde_d = 1'b0;
              estado_d   = ST_IDLE;
            end
          end
        end
        ST_ENTREGA: begin
          acc_d      = '0;
          cuenta_d   = '0;
          desborde_d = 1'b0;
          estado_d   = ST_IDLE;
        end
        default: estado_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      estado_q     <= ST_IDLE;
      tv_q         <= 1'b0;
      modo_q       <= 1'b0;
      primed_q     <= 1'b0;
      acc_q        <= '0;
      cuenta_q     <= '0;
      desborde_q   <= 1'b0;
      digito_q     <= '0;
      digito_stb_q <= 1'b0;
      monto_q      <= '0;
      monto_stb_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      tv_q         <= TECLA_VALIDA;
      modo_q       <= MODO;
      primed_q     <= 1'b1;
      acc_q        <= acc_d;
      cuenta_q     <= cuenta_d;
      desborde_q   <= desborde_d;
      digito_q     <= digito_d;
      digito_stb_q <= digito_stb_d;
      monto_q      <= monto_d;
      monto_stb_q  <= monto_stb_d;
    end
  end

  assign DIGITO         = digito_q;
  assign DIGITO_STB     = digito_stb_q;
  assign MONTO          = monto_q;
  assign MONTO_STB      = monto_stb_q;
  assign DESBORDE       = desborde_q;
  assign CUENTA_DIGITOS = cuenta_q;

endmodule

// File: tb/tb_atm_entrada_teclado.sv
// Bench for atm_entrada_teclado: vector table, directed corner sequences and
// random keypad traffic checked against a digit-queue reference model.
module tb_atm_entrada_teclado;

  localparam int unsigned W     = 32;
  localparam int unsigned MAX_D = 9;
  localparam longint      LIM   = (longint'(1) << W) - 1;

  logic         CLK, RESET, TECLA_VALIDA, MODO;
  logic [3:0]   TECLA;
  logic [3:0]   DIGITO, CUENTA_DIGITOS;
  logic         DIGITO_STB, MONTO_STB, DESBORDE;
  logic [W-1:0] MONTO;

  atm_entrada_teclado #(.ANCHO_MONTO(W), .MAX_DIGITOS(MAX_D)) dut (
    .CLK(CLK), .RESET(RESET), .TECLA_VALIDA(TECLA_VALIDA), .TECLA(TECLA),
    .MODO(MODO), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB), .MONTO(MONTO),
    .MONTO_STB(MONTO_STB), .DESBORDE(DESBORDE), .CUENTA_DIGITOS(CUENTA_DIGITOS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int n_mstb = 0;

  // Reference model: the amount is a queue of accepted decimal digits.
  int     m_digits[$];
  bit     m_tv, m_modo, m_primed, m_entrega;
  bit     e_dstb, e_mstb, e_desb;
  int     e_dig;
  longint e_monto;

  typedef struct {
    logic       tva;
    logic [3:0] tecla;
    logic       modo;
    logic       e_dstb;
    logic [3:0] e_dig;
    logic       e_mstb;
    logic [31:0] e_monto;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t tabla[18];

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint valor();
    longint v = 0;
    foreach (m_digits[i]) v = v * 10 + longint'(m_digits[i]);
    return v;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_tv = 0; m_modo = 0; m_primed = 0; m_entrega = 0;
    e_dstb = 0; e_mstb = 0; e_desb = 0; e_dig = 0; e_monto = 0;
  endtask

  task automatic model_step();
    bit     ev;
    longint nv;
    ev = TECLA_VALIDA && !m_tv;
    e_dstb = 0;
    e_mstb = 0;
    if ((m_primed && (MODO != m_modo)) || m_entrega) begin
      m_digits.delete();
      e_desb = 0;
      m_entrega = 0;
    end else if (ev) begin
      if (!MODO) begin
        if (TECLA <= 4'd9) begin
          e_dig = int'(TECLA);
          e_dstb = 1;
        end
      end else if (TECLA <= 4'd9) begin
        nv = valor() * 10 + longint'(TECLA);
        if (m_digits.size() >= MAX_D || nv > LIM) e_desb = 1;
        else m_digits.push_back(int'(TECLA));
      end else if (TECLA == 4'hA && m_digits.size() > 0) begin
        e_monto = valor();
        e_mstb = 1;
        m_entrega = 1;
      end else if (TECLA == 4'hB) begin
        m_digits.delete();
        e_desb = 0;
      end
    end
    m_tv = TECLA_VALIDA;
    m_modo = MODO;
    m_primed = 1;
  endtask

  // Count and overflow flag are cleared during the strobe cycle, so they are
  // compared only outside it.
  task automatic model_check();
    cmp("digito_stb", 64'(DIGITO_STB), 64'(e_dstb));
    cmp("digito", 64'(DIGITO), 64'(e_dig));
    cmp("monto_stb", 64'(MONTO_STB), 64'(e_mstb));
    cmp("monto", 64'(MONTO), 64'(e_monto));
    if (!e_mstb) begin
      cmp("cuenta", 64'(CUENTA_DIGITOS), 64'(m_digits.size()));
      cmp("desborde", 64'(DESBORDE), 64'(e_desb));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    if (MONTO_STB) n_mstb++;
    model_check();
  endtask

  task automatic press(input logic [3:0] k);
    TECLA_VALIDA = 1'b1; TECLA = k; tick();
    TECLA_VALIDA = 1'b0; tick();
  endtask

  task automatic to_amount_clean();
    TECLA_VALIDA = 1'b0;
    MODO = 1'b0; tick();
    MODO = 1'b1; tick(); tick();
  endtask

  function automatic vec_t mk(input logic tva, input logic [3:0] t, input logic m,
                              input logic ds, input logic [3:0] dg, input logic ms,
                              input logic [31:0] mo, input logic [3:0] c);
    vec_t v;
    v.tva = tva; v.tecla = t; v.modo = m; v.e_dstb = ds; v.e_dig = dg;
    v.e_mstb = ms; v.e_monto = mo; v.e_cnt = c;
    return v;
  endfunction

  initial begin
    int base;
    tabla[0]  = mk(1, 4'd1, 0, 1, 4'd1, 0, 0,   0);
    tabla[1]  = mk(1, 4'd1, 0, 0, 4'd1, 0, 0,   0);
    tabla[2]  = mk(1, 4'd1, 0, 0, 4'd1, 0, 0,   0);
    tabla[3]  = mk(0, 4'd1, 0, 0, 4'd1, 0, 0,   0);
    tabla[4]  = mk(1, 4'd2, 0, 1, 4'd2, 0, 0,   0);
    tabla[5]  = mk(1, 4'd2, 0, 0, 4'd2, 0, 0,   0);
    tabla[6]  = mk(0, 4'd2, 0, 0, 4'd2, 0, 0,   0);
    tabla[7]  = mk(1, 4'hA, 0, 0, 4'd2, 0, 0,   0);
    tabla[8]  = mk(0, 4'hA, 0, 0, 4'd2, 0, 0,   0);
    tabla[9]  = mk(0, 4'hA, 1, 0, 4'd2, 0, 0,   0);
    tabla[10] = mk(1, 4'd5, 1, 0, 4'd2, 0, 0,   1);
    tabla[11] = mk(0, 4'd5, 1, 0, 4'd2, 0, 0,   1);
    tabla[12] = mk(1, 4'd0, 1, 0, 4'd2, 0, 0,   2);
    tabla[13] = mk(0, 4'd0, 1, 0, 4'd2, 0, 0,   2);
    tabla[14] = mk(1, 4'd0, 1, 0, 4'd2, 0, 0,   3);
    tabla[15] = mk(0, 4'd0, 1, 0, 4'd2, 0, 0,   3);
    tabla[16] = mk(1, 4'hA, 1, 0, 4'd2, 1, 500, 3);
    tabla[17] = mk(0, 4'hA, 1, 0, 4'd2, 0, 500, 0);

    RESET = 1'b0; TECLA_VALIDA = 1'b0; TECLA = 4'd0; MODO = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    cmp("rst_digito", 64'(DIGITO), 0);
    cmp("rst_digito_stb", 64'(DIGITO_STB), 0);
    cmp("rst_monto", 64'(MONTO), 0);
    cmp("rst_monto_stb", 64'(MONTO_STB), 0);
    cmp("rst_desborde", 64'(DESBORDE), 0);
    cmp("rst_cuenta", 64'(CUENTA_DIGITOS), 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;

    // Vector table: PIN digits with held keys, then the 5,0,0,ENTER amount.
    for (int i = 0; i < 18; i++) begin
      TECLA_VALIDA = tabla[i].tva; TECLA = tabla[i].tecla; MODO = tabla[i].modo;
      tick();
      cmp($sformatf("tab%0d_dstb", i), 64'(DIGITO_STB), 64'(tabla[i].e_dstb));
      cmp($sformatf("tab%0d_dig", i), 64'(DIGITO), 64'(tabla[i].e_dig));
      cmp($sformatf("tab%0d_mstb", i), 64'(MONTO_STB), 64'(tabla[i].e_mstb));
      cmp($sformatf("tab%0d_monto", i), 64'(MONTO), 64'(tabla[i].e_monto));
      if (!tabla[i].e_mstb)
        cmp($sformatf("tab%0d_cnt", i), 64'(CUENTA_DIGITOS), 64'(tabla[i].e_cnt));
    end

    // Ten 9s: the tenth is dropped and flagged.
    to_amount_clean();
    for (int i = 0; i < 10; i++) press(4'd9);
    cmp("t3_desborde", 64'(DESBORDE), 1);
    cmp("t3_cuenta", 64'(CUENTA_DIGITOS), 9);
    TECLA_VALIDA = 1'b1; TECLA = 4'hA; tick();
    cmp("t3_mstb", 64'(MONTO_STB), 1);
    cmp("t3_monto", 64'(MONTO), 999999999);
    TECLA_VALIDA = 1'b0; tick();
    cmp("t3_mstb_off", 64'(MONTO_STB), 0);
    tick();
    cmp("t3_desborde_clr", 64'(DESBORDE), 0);

    // CLEAR then ENTER on an empty amount gives no strobe.
    to_amount_clean();
    press(4'd7);
    press(4'hB);
    cmp("t4_cuenta_clr", 64'(CUENTA_DIGITOS), 0);
    base = n_mstb;
    press(4'hA);
    cmp("t4_no_stb", 64'(n_mstb - base), 0);
    TECLA_VALIDA = 1'b1; TECLA = 4'd3; tick();
    TECLA_VALIDA = 1'b0; tick();
    TECLA_VALIDA = 1'b1; TECLA = 4'hA; tick();
    cmp("t4_mstb", 64'(MONTO_STB), 1);
    cmp("t4_monto", 64'(MONTO), 3);
    TECLA_VALIDA = 1'b0; tick();

    // Mode switch mid-amount discards the accumulator.
    to_amount_clean();
    base = n_mstb;
    press(4'd4);
    press(4'd2);
    cmp("t5_cuenta2", 64'(CUENTA_DIGITOS), 2);
    MODO = 1'b0; tick();
    cmp("t5_cuenta_clr", 64'(CUENTA_DIGITOS), 0);
    TECLA_VALIDA = 1'b1; TECLA = 4'd9; tick();
    cmp("t5_dstb", 64'(DIGITO_STB), 1);
    cmp("t5_digito", 64'(DIGITO), 9);
    TECLA_VALIDA = 1'b0; tick();
    cmp("t5_no_mstb", 64'(n_mstb - base), 0);

    // Async reset mid-amount clears everything before the next edge.
    to_amount_clean();
    press(4'd8);
    press(4'd8);
    cmp("t6_cuenta2", 64'(CUENTA_DIGITOS), 2);
    #2;
    RESET = 1'b0;
    model_reset();
    #1;
    cmp("t6_cuenta", 64'(CUENTA_DIGITOS), 0);
    cmp("t6_monto", 64'(MONTO), 0);
    cmp("t6_digito", 64'(DIGITO), 0);
    cmp("t6_desborde", 64'(DESBORDE), 0);
    cmp("t6_stbs", 64'({DIGITO_STB, MONTO_STB}), 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    base = n_mstb;
    press(4'hA);
    tick();
    cmp("t6_no_stb", 64'(n_mstb - base), 0);

    // Random keypad traffic against the model.
    TECLA_VALIDA = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      int r;
      if ($urandom_range(0, 99) < 3) MODO = ~MODO;
      if (TECLA_VALIDA) begin
        if ($urandom_range(0, 1) == 0) TECLA_VALIDA = 1'b0;
      end else if ($urandom_range(0, 9) < 4) begin
        TECLA_VALIDA = 1'b1;
        r = int'($urandom_range(0, 99));
        if (r < 70) TECLA = 4'($urandom_range(0, 9));
        else if (r < 85) TECLA = 4'hA;
        else if (r < 95) TECLA = 4'hB;
        else TECLA = 4'($urandom_range(12, 15));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
